// File: rtl/ula_op_sequencer_if.sv
// ULA shared-bus bundle: request, operand, enable and result signals.
// master = sequencer side, slave = request source / function-unit side.
interface ula_op_sequencer_if #(
  parameter int NUM_UNITS = 4
);
  logic                 start;
  logic [2:0]           op;
  logic [7:0]           a_in;
  logic [7:0]           b_in;
  logic [7:0]           a_op;
  logic [7:0]           b_op;
  logic [NUM_UNITS-1:0] en;
  logic [7:0]           bus;
  logic [7:0]           acc;
  logic                 zero;
  logic                 neg;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    input  start, op, a_in, b_in, bus,
    output a_op, b_op, en, acc, zero, neg,
    output busy, done, err
  );

  modport slave (
    output start, op, a_in, b_in, bus,
    input  a_op, b_op, en, acc, zero, neg,
    input  busy, done, err
  );
endinterface

// File: rtl/ula_op_sequencer.sv
// ULA op sequencer: latches a request, enables one bus unit,
// then captures the bus into an accumulator with zero/neg flags.
module ula_op_sequencer #(
  parameter int NUM_UNITS     = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  ula_op_sequencer_if.master io
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [7:0]           a_op_q, a_op_d;
  logic [7:0]           b_op_q, b_op_d;
  logic [NUM_UNITS-1:0] en_q, en_d;
  logic [7:0]           acc_q, acc_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  function automatic logic is_legal(
    input logic [2:0] o
  );
    return {29'd0, o} < 32'(NUM_UNITS);
  endfunction

  // Out-of-range ops decode to no enable at all.
  function automatic logic [NUM_UNITS-1:0] dec(
    input logic [2:0] o
  );
    logic [NUM_UNITS-1:0] r;
    for (int i = 0; i < NUM_UNITS; i++)
      r[i] = ({29'd0, o} == 32'(i));
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_op_d  = a_op_q;
    b_op_d  = b_op_q;
    en_d    = en_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = DRIVE;
          a_op_d  = io.a_in;
          b_op_d  = io.b_in;
          op_d    = io.op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          en_d    = dec(io.op);
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          en_d    = '0;
          done_d  = 1'b1;
          err_d   = ~is_legal(op_q);
          if (is_legal(op_q)) begin
            acc_d  = io.bus;
            zero_d = (io.bus == 8'h00);
            neg_d  = io.bus[7];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      en_q    <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign io.a_op = a_op_q;
  assign io.b_op = b_op_q;
  assign io.en   = en_q;
  assign io.acc  = acc_q;
  assign io.zero = zero_q;
  assign io.neg  = neg_q;
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.err  = err_q;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Directed bench for ula_op_sequencer: one instance with a
// one-cycle settle, one with a three-cycle settle.
module tb_ula_op_sequencer;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ula_op_sequencer_if #(.NUM_UNITS(4)) if0 ();
  ula_op_sequencer_if #(.NUM_UNITS(4)) if1 ();

  ula_op_sequencer #(
    .NUM_UNITS(4),
    .SETTLE_CYCLES(1)
  ) u0 (
    .clk(clk),
    .rst(rst0),
    .io (if0)
  );

  ula_op_sequencer #(
    .NUM_UNITS(4),
    .SETTLE_CYCLES(3)
  ) u1 (
    .clk(clk),
    .rst(rst1),
    .io (if1)
  );

  // Units: 0 AND, 1 OR, 2 XOR, 3 ADD; undriven bus reads 0.
  function automatic logic [7:0] unit_out(
    input logic [3:0] en,
    input logic [7:0] a,
    input logic [7:0] b
  );
    if (en[0]) return a & b;
    if (en[1]) return a | b;
    if (en[2]) return a ^ b;
    if (en[3]) return a + b;
    return 8'h00;
  endfunction

  assign if0.bus = unit_out(if0.en, if0.a_op, if0.b_op);
  assign if1.bus = unit_out(if1.en, if1.a_op, if1.b_op);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Full op on the 1-cycle instance, checked cycle by cycle.
  task automatic op0(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] xen,
    input logic [7:0] xacc,
    input logic       xz,
    input logic       xn,
    input logic       xerr
  );
    if0.start = 1'b1;
    if0.op    = op;
    if0.a_in  = a;
    if0.b_in  = b;
    @(negedge clk);
    if0.start = 1'b0;
    chk("en_drive", 32'(if0.en), 32'(xen));
    chk("busy_drive", 32'(if0.busy), 1);
    chk("done_drive", 32'(if0.done), 0);
    @(negedge clk);
    chk("done_pulse", 32'(if0.done), 1);
    chk("en_done", 32'(if0.en), 0);
    chk("err", 32'(if0.err), 32'(xerr));
    chk("acc", 32'(if0.acc), 32'(xacc));
    chk("zero", 32'(if0.zero), 32'(xz));
    chk("neg", 32'(if0.neg), 32'(xn));
    @(negedge clk);
    chk("busy_idle", 32'(if0.busy), 0);
    chk("done_idle", 32'(if0.done), 0);
    chk("a_op_hold", 32'(if0.a_op), 32'(a));
    chk("b_op_hold", 32'(if0.b_op), 32'(b));
  endtask

  initial begin
    int       ndone;
    logic [3:0] en_or;
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.start = 1'b0; if0.op = '0;
    if0.a_in = '0; if0.b_in = '0;
    if1.start = 1'b0; if1.op = '0;
    if1.a_in = '0; if1.b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_acc", 32'(if0.acc), 0);
    chk("rst_zero", 32'(if0.zero), 1);
    chk("rst_neg", 32'(if0.neg), 0);
    chk("rst_en", 32'(if0.en), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_done", 32'(if0.done), 0);
    chk("rst_aop", 32'(if0.a_op), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    op0(3'd0, 8'hF0, 8'h3C, 4'b0001, 8'h30, 1'b0, 1'b0, 1'b0);
    op0(3'd0, 8'h0F, 8'hF0, 4'b0001, 8'h00, 1'b1, 1'b0, 1'b0);
    op0(3'd0, 8'hFF, 8'hFF, 4'b0001, 8'hFF, 1'b0, 1'b1, 1'b0);
    op0(3'd1, 8'h12, 8'h40, 4'b0010, 8'h52, 1'b0, 1'b0, 1'b0);
    op0(3'd3, 8'h80, 8'h7F, 4'b1000, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Second start one cycle later must be ignored.
    if0.start = 1'b1; if0.op = 3'd0;
    if0.a_in = 8'hAA; if0.b_in = 8'h0F;
    @(negedge clk);
    en_or = if0.en;
    ndone = 0;
    if0.op = 3'd1; if0.a_in = 8'h55;
    @(negedge clk);
    if0.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en_or |= if0.en;
      if (if0.done) ndone++;
      @(negedge clk);
    end
    chk("ign_en", 32'(en_or), 32'h1);
    chk("ign_ndone", 32'(ndone), 1);
    chk("ign_acc", 32'(if0.acc), 32'h0A);

    op0(3'd5, 8'h11, 8'h22, 4'b0000, 8'h0A, 1'b0, 1'b0, 1'b1);
    op0(3'd4, 8'h33, 8'h44, 4'b0000, 8'h0A, 1'b0, 1'b0, 1'b1);

    // Three-cycle settle: en for N+1..N+3, done at N+4.
    if1.start = 1'b1; if1.op = 3'd2;
    if1.a_in = 8'h5A; if1.b_in = 8'hFF;
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("s3_en", 32'(if1.en), 32'h4);
      chk("s3_nodone", 32'(if1.done), 0);
      @(negedge clk);
    end
    chk("s3_done", 32'(if1.done), 1);
    chk("s3_en_off", 32'(if1.en), 0);
    chk("s3_acc", 32'(if1.acc), 32'hA5);
    chk("s3_neg", 32'(if1.neg), 1);
    @(negedge clk);
    chk("s3_idle", 32'(if1.busy), 0);

    // Reset lands mid-DRIVE.
    if1.start = 1'b1; if1.op = 3'd0;
    if1.a_in = 8'hFF; if1.b_in = 8'hFF;
    @(negedge clk);
    if1.start = 1'b0;
    chk("mr_en1", 32'(if1.en), 32'h1);
    @(negedge clk);
    chk("mr_en2", 32'(if1.en), 32'h1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("mr_en", 32'(if1.en), 0);
    chk("mr_acc", 32'(if1.acc), 0);
    chk("mr_zero", 32'(if1.zero), 1);
    chk("mr_busy", 32'(if1.busy), 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (if1.done) ndone++;
      @(negedge clk);
    end
    chk("mr_nodone", 32'(ndone), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // en must never be multi-hot.
  always @(negedge clk) begin
    if (!$onehot0(if0.en))
      chk("onehot0", 32'(if0.en), 0);
    if (!$onehot0(if1.en))
      chk("onehot1", 32'(if1.en), 0);
  end

endmodule
